gbuff_port_arbiter: RTL

//  Shares one single-port global buffer (SRAM, synchronous read) among NREQ requesters,
//  e.g. the tile loader, the MAXP input reader and the MAXP writeback.

---
 rtl/gbuff_port_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gbuff_port_arbiter.sv
// rtl/gbuff_port_arbiter.sv - round-robin arbiter with burst lock sharing one single-port global buffer
module gbuff_port_arbiter #(
    parameter int NREQ      = 3,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        lock_i,
    input  logic [NREQ-1:0]        wen_i,
    input  logic [NREQ*ADDR_W-1:0] addr_i,
    input  logic [NREQ*DATA_W-1:0] wdata_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic [NREQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   sram_wen_o,
    output logic [ADDR_W-1:0]      sram_addr_o,
    output logic [DATA_W-1:0]      sram_di_o,
    input  logic [DATA_W-1:0]      sram_do_i
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;

    logic [NREQ-1:0]  rd_pipe_q [RD_LAT];

    // Requester index following i, wrapping at NREQ (NREQ need not be a power of two).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    // Pick this cycle's winner: rotating search from ptr when open, only the owner during a burst.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (state_q == ST_IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= NREQ) begin
                    cand = cand - NREQ;
                end
                cand_idx = IDX_W'(cand);
                if (!grant_vld && req_i[cand_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end else begin
            grant_vld = req_i[owner_q];
            grant_idx = owner_q;
        end
        // Nothing reaches the SRAM while reset is held, even with requests pending.
        if (!rst_ni) begin
            grant_vld = 1'b0;
        end
    end

    // One-hot grant and the SRAM request mux; idle cycles park the SRAM bus at zero.
    always_comb begin
        gnt_o       = '0;
        sram_wen_o  = 1'b0;
        sram_addr_o = '0;
        sram_di_o   = '0;
        if (grant_vld) begin
            gnt_o       = NREQ'(1) << grant_idx;
            sram_wen_o  = wen_i[grant_idx];
            sram_addr_o = addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
            sram_di_o   = wdata_i[int'(grant_idx)*DATA_W +: DATA_W];
        end
    end

    // Arbitration state update: burst entry on a locked grant, exit on unlock or beat limit.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == ST_IDLE) begin
            if (grant_vld) begin
                ptr_d = next_idx(grant_idx);
                if (lock_i[grant_idx] && (MAX_BURST > 1)) begin
                    state_d    = ST_BURST;
                    owner_d    = grant_idx;
                    beat_cnt_d = CNT_W'(1);
                end
            end
        end else begin
            if (grant_vld) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
            // beat_cnt_d counts this cycle's beat, so a burst never exceeds MAX_BURST grants.
            if (!lock_i[owner_q] || (grant_vld && (beat_cnt_d == CNT_W'(MAX_BURST)))) begin
                state_d    = ST_IDLE;
                ptr_d      = next_idx(owner_q);
                beat_cnt_d = '0;
            end
        end
    end

    // Arbiter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Read-return tag pipeline; it tracks the SRAM read latency so ids line up with sram_do.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            rd_pipe_q[0] <= (grant_vld && !wen_i[grant_idx]) ? gnt_o : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    // Return strobe comes straight from the last pipeline stage; data is forwarded only with it.
    always_comb begin
        rvalid_o = rd_pipe_q[RD_LAT-1];
        rdata_o  = (|rd_pipe_q[RD_LAT-1]) ? sram_do_i : '0;
    end

endmodule
